// File: rtl/adder_sweep_pkg.sv
// Shared types and defaults for the adder operand sweep driver.
package adder_sweep_pkg;

  localparam int DEF_WIDTH         = 3;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Clock cycles from an accepted start edge to done.
  function automatic int sweep_cycles(input int width, input int settle);
    return (1 << (2 * width)) * (settle + 1);
  endfunction

endpackage

// File: rtl/adder_sweep_driver_if.sv
// Operand/sum bus between the sweep driver and the adder under test.
interface adder_sweep_driver_if
  import adder_sweep_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  // No handshake: the driver holds a_out/b_out stable and samples sum_in
  // a fixed number of cycles later, so the adder only needs to settle in time.
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH:0]   sum_in;

  modport master (output a_out, output b_out, input sum_in);
  modport slave  (input a_out, input b_out, output sum_in);
endinterface

// File: rtl/adder_sweep_driver_operand_counter.sv
// Walks every {a, b} operand pair; b is the low half so it advances first.
module operand_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             last
);
  localparam logic [2*WIDTH-1:0] PAIR_ONE = 1;

  logic [2*WIDTH-1:0] pair_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pair_q <= '0;
    end else if (inc) begin
      pair_q <= pair_q + PAIR_ONE;
    end
  end

  assign {a, b} = pair_q;
  assign last   = &pair_q;
endmodule

// File: rtl/adder_sweep_driver.sv
// Sweeps all operand pairs through an external adder and checks each sum.
// Optional ADDER_SWEEP_STOP_ON_FAIL_EN: halt in DONE on the first mismatch.
module adder_sweep_driver
  import adder_sweep_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  adder_sweep_driver_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*WIDTH:0]      err_count,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b,
  output state_t                dbg_state
);
  localparam logic [3:0]       SETTLE_RELOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       CNT_ONE       = 4'd1;
  localparam logic [2*WIDTH:0] ERR_ONE       = 1;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               start_q, armed_q, start_rise;
  logic               ctr_clr, ctr_inc, last_pair;
  logic [WIDTH-1:0]   a_cur, b_cur;
  logic [WIDTH:0]     exp_sum;
  logic               mismatch, stop_now;
  logic [2*WIDTH:0]   err_d, err_sat;
  logic [WIDTH-1:0]   fail_a_d, fail_b_d;
  logic               pass_d;

  operand_counter #(.WIDTH(WIDTH)) u_operand_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .a    (a_cur),
    .b    (b_cur),
    .last (last_pair)
  );

  assign bus.a_out = a_cur;
  assign bus.b_out = b_cur;

  // armed_q masks the first edge after reset so a start held through reset
  // is not mistaken for a fresh rising edge.
  assign start_rise = start & ~start_q & armed_q;
  assign exp_sum    = {1'b0, a_cur} + {1'b0, b_cur};
  assign mismatch   = (bus.sum_in != exp_sum);
  assign err_sat    = (&err_count) ? err_count : err_count + ERR_ONE;

`ifdef ADDER_SWEEP_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ctr_clr  = 1'b0;
    ctr_inc  = 1'b0;
    err_d    = err_count;
    fail_a_d = fail_a;
    fail_b_d = fail_b;
    pass_d   = pass;
    case (state_q)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d  = SETTLE;
          cnt_d    = SETTLE_RELOAD;
          ctr_clr  = 1'b1;
          err_d    = '0;
          fail_a_d = '0;
          fail_b_d = '0;
          pass_d   = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) state_d = CHECK;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_sat;
          if (err_count == '0) begin
            fail_a_d = a_cur;
            fail_b_d = b_cur;
          end
        end
        if (stop_now || last_pair) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end else begin
          ctr_inc = 1'b1;
          state_d = SETTLE;
          cnt_d   = SETTLE_RELOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start;
      armed_q   <= 1'b1;
      err_count <= err_d;
      fail_a    <= fail_a_d;
      fail_b    <= fail_b_d;
      pass      <= pass_d;
    end
  end

  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_adder_sweep_driver.sv
// Bench for adder_sweep_driver: default-settle DUT with selectable faulty
// adders, plus a SETTLE_CYCLES=1 DUT driving registered adder models.
module tb_adder_sweep_driver;
  import adder_sweep_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start0 = 1'b0;
  logic start1 = 1'b0;

  adder_sweep_driver_if #(.WIDTH(3)) bus0 ();
  adder_sweep_driver_if #(.WIDTH(3)) bus1 ();

  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] err0, err1;
  logic [2:0] fa0, fb0, fa1, fb1;
  state_t     st0, st1;

  adder_sweep_driver #(.WIDTH(3), .SETTLE_CYCLES(2)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0.master),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_a(fa0), .fail_b(fb0), .dbg_state(st0)
  );

  adder_sweep_driver #(.WIDTH(3), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1.master),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_a(fa1), .fail_b(fb1), .dbg_state(st1)
  );

  // ---------------- adder models ----------------
  // mode 0: correct, 1: Sum[0] stuck at 0, 2: wrong only for 5+6
  function automatic logic [3:0] adder_fn(input int mode, input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = 4'(a) + 4'(b);
    case (mode)
      1: s[0] = 1'b0;
      2: if (a == 3'd5 && b == 3'd6) s = 4'd10;
      default: ;
    endcase
    return s;
  endfunction

  int amode = 0;
  int lmode = 0;
  always_comb bus0.sum_in = adder_fn(amode, bus0.a_out, bus0.b_out);

  logic [3:0] r1, r2;
  always @(posedge clk) begin
    r1 <= 4'(bus1.a_out) + 4'(bus1.b_out);
    r2 <= r1;
  end
  assign bus1.sum_in = (lmode == 0) ? r1 : r2;

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Run model: outcome from exhaustive pair arithmetic, timing from cycle offset.
  bit mdl_on = 1'b0;
  int t0, mdl_err, mdl_first, mdl_end_k, mdl_end_a, mdl_end_b;

  task automatic model_setup(input int mode);
    int sa, sb;
    mdl_err   = 0;
    mdl_first = -1;
    for (int p = 0; p < 64; p++) begin
      sa = p / 8;
      sb = p % 8;
      if (int'(adder_fn(mode, 3'(sa), 3'(sb))) != sa + sb) begin
        if (mdl_first < 0) mdl_first = p;
        mdl_err++;
      end
    end
    mdl_end_k = 192;
    mdl_end_a = 7;
    mdl_end_b = 7;
`ifdef ADDER_SWEEP_STOP_ON_FAIL_EN
    if (mdl_first >= 0) begin
      mdl_err   = 1;
      mdl_end_k = (mdl_first + 1) * 3;
      mdl_end_a = mdl_first / 8;
      mdl_end_b = mdl_first % 8;
    end
`endif
  endtask

  int cmp_k, cmp_idx;
  always @(negedge clk) begin
    if (mdl_on) begin
      cmp_k = cyc - t0;
      if (cmp_k >= 0) begin
        if (cmp_k < mdl_end_k) begin
          cmp_idx = cmp_k / 3;
          chk("busy_run", busy0, 1);
          chk("done_run", done0, 0);
          chk("pass_run", pass0, 0);
          chk("a_out_run", bus0.a_out, cmp_idx / 8);
          chk("b_out_run", bus0.b_out, cmp_idx % 8);
        end else begin
          chk("busy_done", busy0, 0);
          chk("done_done", done0, 1);
          chk("pass_done", pass0, (mdl_err == 0) ? 1 : 0);
          chk("err_done", err0, mdl_err);
          chk("fail_a_done", fa0, (mdl_first >= 0) ? mdl_first / 8 : 0);
          chk("fail_b_done", fb0, (mdl_first >= 0) ? mdl_first % 8 : 0);
          chk("a_out_done", bus0.a_out, mdl_end_a);
          chk("b_out_done", bus0.b_out, mdl_end_b);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start0(input int mode);
    @(negedge clk);
    amode = mode;
    model_setup(mode);
    t0 = cyc + 1;
    start0 = 1'b1;
    mdl_on = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input string name, output int lat);
    int n;
    n = 0;
    while (!done0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done0) chk({name, "_timeout"}, 0, 1);
    lat = cyc - t0;
  endtask

  task automatic finish_run0();
    repeat (3) @(negedge clk);
    mdl_on = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_dut1(input int mode, output int lat);
    int n, t1;
    @(negedge clk);
    lmode = mode;
    t1 = cyc + 1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (!done1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done1) chk("dut1_timeout", 0, 1);
    lat = cyc - t1;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_err", err0, 0);
    chk("rst_a_out", bus0.a_out, 0);
    chk("rst_state", int'(st0), int'(IDLE));
    chk("rst_done1", done1, 0);
    rst = 1'b0;

    // correct adder, start around cycle 5
    pulse_start0(0);
    wait_done0("t1", lat);
    chk("t1_latency", lat, 192);
    chk("t1_pass", pass0, 1);
    chk("t1_err", err0, 0);
    chk("t1_fail_a", fa0, 0);
    chk("t1_fail_b", fb0, 0);
    finish_run0();

    // Sum[0] stuck at 0, restarted from DONE
    pulse_start0(1);
    wait_done0("t2", lat);
    chk("t2_pass", pass0, 0);
`ifdef ADDER_SWEEP_STOP_ON_FAIL_EN
    chk("t2_err", err0, 1);
`else
    chk("t2_err", err0, 32);
`endif
    chk("t2_fail_a", fa0, 0);
    chk("t2_fail_b", fb0, 1);
    finish_run0();

    // single bad pair 5+6
    pulse_start0(2);
    wait_done0("t3", lat);
    chk("t3_err", err0, 1);
    chk("t3_fail_a", fa0, 5);
    chk("t3_fail_b", fb0, 6);
`ifdef ADDER_SWEEP_STOP_ON_FAIL_EN
    chk("t3_hold_a", bus0.a_out, 5);
    chk("t3_hold_b", bus0.b_out, 6);
`endif
    finish_run0();

    // second start edge mid-sweep must be ignored
    pulse_start0(0);
    repeat (49) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0("t4", lat);
    chk("t4_latency", lat, 192);
    chk("t4_pass", pass0, 1);
    finish_run0();

    // reset mid-sweep with start held high
    @(negedge clk);
    amode = 1;
    model_setup(1);
    t0 = cyc + 1;
    start0 = 1'b1;
    mdl_on = 1'b1;
    repeat (40) @(negedge clk);
    mdl_on = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_busy", busy0, 0);
    chk("t5_done", done0, 0);
    chk("t5_err", err0, 0);
    chk("t5_fail_a", fa0, 0);
    chk("t5_fail_b", fb0, 0);
    chk("t5_b_out", bus0.b_out, 0);
    repeat (5) @(negedge clk);
    chk("t5_stay_idle", int'(st0), int'(IDLE));
    chk("t5_stay_busy", busy0, 0);
    start0 = 1'b0;
    @(negedge clk);
    pulse_start0(0);
    wait_done0("t5_rerun", lat);
    chk("t5_latency", lat, 192);
    chk("t5_pass", pass0, 1);
    finish_run0();

    // SETTLE_CYCLES=1: 1-cycle registered adder passes, 2-cycle does not
    run_dut1(0, lat);
    chk("t6_latency", lat, 128);
    chk("t6_pass", pass1, 1);
    chk("t6_err", err1, 0);
    run_dut1(1, lat);
    chk("t6_slow_pass", pass1, 0);
    chk("t6_slow_err_nonzero", (err1 != 0) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
